// File: rtl/pp_row_accumulator.sv
// pp_row_accumulator: reduces an N*N partial-product vector to the 2N-bit
// product by shift-add, one partial-product row per clock.
// Optional feature macro: PPACC_EARLY_EXIT_EN. When it is defined, the block
// finishes as soon as every row above the current one is zero.
module pp_row_accumulator #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*N-1:0]   pp,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*N-1:0]   product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned PP_W  = N * N;
  localparam int unsigned ACC_W = 2 * N;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PP_W-1:0]    pp_q, pp_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [N-1:0]       row_c;
  logic               last_row_c;
  logic               accept_c;

  // Select the latched row addressed by the row counter.
  always_comb begin
    row_c = '0;
    for (int unsigned r = 0; r < N; r++) begin
      if (cnt_q == CNT_W'(r)) row_c = pp_q[r*N +: N];
    end
  end

`ifdef PPACC_EARLY_EXIT_EN
  logic upper_nz_c;

  // Finish early when no nonzero row remains above the one being added.
  always_comb begin
    upper_nz_c = 1'b0;
    for (int unsigned r = 0; r < N; r++) begin
      if ((r > 32'(cnt_q)) && (pp_q[r*N +: N] != '0)) upper_nz_c = 1'b1;
    end
    last_row_c = (cnt_q == CNT_W'(N - 1)) || !upper_nz_c;
  end
`else
  // Fixed latency: the last row is always row N-1.
  always_comb begin
    last_row_c = (cnt_q == CNT_W'(N - 1));
  end
`endif

  // Next-state, handshake and datapath update.
  always_comb begin
    state_d  = state_q;
    pp_d     = pp_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept_c = in_valid && in_ready;

    unique case (state_q)
      IDLE: ;
      ACCUM: begin
        acc_d = acc_q + (ACC_W'(row_c) << cnt_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (last_row_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new operand overrides the DONE->IDLE exit for back-to-back operation.
    if (accept_c) begin
      pp_d    = pp;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ACCUM;
    end

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ACCUM);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pp_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pp_q        <= pp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign product   = acc_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Testbench for pp_row_accumulator: directed cases plus randomized A,B pairs
// checked against A*B with a result queue.
module tb_pp_row_accumulator;

  localparam int unsigned N = 4;
`ifdef PPACC_EARLY_EXIT_EN
  localparam int T2_LAT = 2;
  localparam int T3_LAT = 1;
`else
  localparam int T2_LAT = 4;
  localparam int T3_LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  pp = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   product;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  pp_row_accumulator #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pp        (pp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Partial products of A and B: bit i*N+j = A[i] & B[j].
  function automatic logic [15:0] mk_pp(input logic [3:0] a, input logic [3:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[i*4+j] = a[i] & b[j];
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input string tag, input logic [15:0] p);
    pp = p;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts clocks until out_valid.
  task automatic wait_result(input string tag, input logic [7:0] exp_p, input int exp_l);
    int lat;
    lat = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_l));
    chk({tag, "_product"}, 32'(product), 32'(exp_p));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] cur;
  logic [7:0] held_p;
  logic       held;
  logic [3:0] a, b;
  int         sent, recv;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: F*F
    out_ready = 1'b1;
    do_accept("t1", 16'hFFFF);
    wait_result("t1", 8'hE1, 4);
    step();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd1);

    // 2: 3*5
    do_accept("t2", 16'h0055);
    wait_result("t2", 8'h0F, T2_LAT);
    step();

    // 3: zero operand
    do_accept("t3", 16'h0000);
    wait_result("t3", 8'h00, T3_LAT);
    step();

    // 4: stalled consumer, then back-to-back accept
    out_ready = 1'b0;
    do_accept("t4", 16'h1111);
    wait_result("t4", 8'h0F, 4);
    pp = 16'hFFFF;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_product", 32'(product), 32'h0F);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_b2b_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_b2b_valid", 32'(out_valid), 32'd0);
    wait_result("t4b", 8'hE1, 4);
    step();

    // 5: reset in the middle of accumulation
    do_accept("t5", 16'hFFFF);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_product", 32'(product), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_no_pulse", 32'(out_valid), 32'd0);
    end
    do_accept("t5b", 16'hF000);
    wait_result("t5b", 8'h78, 4);
    step();

    // 6: random operands, random back-pressure
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_p = '0;
    cur = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
      if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        a = 4'($urandom);
        b = 4'($urandom);
        pp = mk_pp(a, b);
        cur = 8'(a) * 8'(b);
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      #1;
      if (held) begin
        chk("r_hold_valid", 32'(out_valid), 32'd1);
        chk("r_hold_product", 32'(product), 32'(held_p));
      end
      held = out_valid && !out_ready;
      held_p = product;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("r_spurious", 32'd1, 32'd0);
        else chk("r_product", 32'(product), 32'(q.pop_front()));
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(cur);
        sent++;
        step();
        in_valid = 1'b0;
      end else begin
        step();
      end
    end
    chk("r_count", 32'(recv), 32'd1000);
    chk("r_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
